muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer attached to the EX stage. It accepts MULT/MULTU/DIV/DIVU from the ID/EX register using already-forwarded operands and runs a 32-step radix-2 algorithm. It stalls the front of the pipeline while busy and owns the architectural HI/LO registers, including MTHI/MTLO writes. The block is the single owner of the shared iterative arithmetic resource and schedules all access to it.

---
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/DIVU complete immediately as no-ops.
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
  logic              neg_q;
  logic              accept, op_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   res_hi, res_lo;
`ifdef MULDIV_DIV_EN
  logic              is_div, neg_r, div0;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
`endif

  assign accept    = start & ~flush & (state != S_RUN);
  assign op_signed = ~op[0];
  assign sign_a    = op_signed & opa[XLEN-1];
  assign sign_b    = op_signed & opb[XLEN-1];
  assign mag_a     = sign_a ? -opa : opa;
  assign mag_b     = sign_b ? -opb : opb;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (flush)            state_nxt = S_IDLE;
        else if (count == '0) state_nxt = S_DONE;
      end
      default: begin
        if (accept) begin
`ifdef MULDIV_DIV_EN
          state_nxt = S_RUN;
`else
          state_nxt = op[1] ? S_DONE : S_RUN;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    stall = accept | (state == S_RUN);
    busy  = (state == S_RUN);
    done  = (state == S_DONE);
  end

  // One radix-2 step: multiply shifts {carry,acc_hi,acc_lo} right, divide shifts {acc_hi,acc_lo} left.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = (div_diff[XLEN+1:XLEN] == 2'b00);
    if (is_div) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], div_ok};
    end
`endif
  end

  // Divide by zero naturally leaves all-ones quotient and the dividend magnitude as remainder.
  always_comb begin
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    res_hi   = prod_fix[2*XLEN-1:XLEN];
    res_lo   = prod_fix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      res_lo = div0 ? '1 : (neg_q ? -step_lo : step_lo);
      res_hi = neg_r ? -step_hi : step_hi;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      count  <= count - 1'b1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (!flush && count == '0) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      if (accept) begin
        count  <= CW'(XLEN - 1);
        acc_hi <= '0;
        neg_q  <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
        acc_lo <= op[1] ? mag_a : mag_b;
        opnd   <= op[1] ? mag_b : mag_a;
        is_div <= op[1];
        neg_r  <= sign_a;
        div0   <= (opb == '0);
`else
        acc_lo <= mag_b;
        opnd   <= mag_a;
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl.
// Divide vectors are selected by MULDIV_DIV_EN to match the build under test.
module tb_muldiv_ctrl;

  logic        clk, reset, start, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
  endtask

  // Entered in the cycle start is asserted; returns in the DONE cycle.
  task automatic wait_done(input string tag, input int exp_stall,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt = 0;
    int i = 0;
    #1;
    if (stall) cnt++;
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    while (!done && i < 60) begin
      if (stall) cnt++;
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " stall cycles"}, cnt, exp_stall);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset stall", stall, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu max", 33, 32'hFFFFFFFE, 32'h00000001);
    step();
    check("multu done pulse", done, 0);

    issue(MULT, 32'hFFFFFFFD, 32'd7);
    wait_done("mult -3x7", 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    step();

`ifdef MULDIV_DIV_EN
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div -7/2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    step();
    issue(DIVU, 32'd100, 32'd0);
    wait_done("divu 100/0", 33, 32'd100, 32'hFFFFFFFF);
    step();
    issue(DIV, 32'hFFFFFFF9, 32'd0);
    wait_done("div -7/0", 33, 32'hFFFFFFF9, 32'hFFFFFFFF);
    step();
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div min/-1", 33, 32'h00000000, 32'h80000000);
    step();
    hi_we = 1'b1; wdata = 32'h1234;
    step();
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo kept", lo, 32'h80000000);
`else
    issue(DIVU, 32'd9, 32'd3);
    wait_done("divu nodiv", 1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    step();
    check("divu nodiv pulse", done, 0);
    hi_we = 1'b1; wdata = 32'h1234;
    step();
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo kept", lo, 32'hFFFFFFEB);
`endif

    lo_we = 1'b1; wdata = 32'h5678;
    step();
    lo_we = 1'b0;
    check("mtlo lo", lo, 32'h5678);

    issue(MULTU, 32'd2, 32'd3);
    wait_done("b2b first", 33, 32'h0, 32'd6);
    issue(MULTU, 32'd4, 32'd5);
    wait_done("b2b second", 33, 32'h0, 32'd20);
    step();

    issue(MULTU, 32'd5, 32'd5);
    step();
    start = 1'b0;
    repeat (4) step();
    hi_we = 1'b1; wdata = 32'hDEAD;
    step();
    hi_we = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    #1;
    check("flush busy before", busy, 1);
    check("flush stall in run", stall, 1);
    step();
    flush = 1'b0;
    #1;
    check("flush busy after", busy, 0);
    check("flush stall after", stall, 0);
    check("flush hi held", hi, 32'h0);
    check("flush lo held", lo, 32'd20);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      step();
    end
    check("flush no done", dcnt, 0);

    hi_we = 1'b1; wdata = 32'hAAAA;
    step();
    hi_we = 1'b0;
    check("mthi before reset", hi, 32'hAAAA);
    issue(MULTU, 32'd5, 32'd5);
    step();
    start = 1'b0;
    repeat (19) step();
    check("reset busy before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrun reset hi", hi, 32'h0);
    check("midrun reset lo", lo, 32'h0);
    check("midrun reset stall", stall, 0);
    check("midrun reset busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
